pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, ME, WB).
//  - Detects load-use hazards (ID vs EX) and inserts one bubble.
//  - Redirects and flushes on a taken branch/jump resolved in EX.
//  - Runs the data-memory handshake for the instruction in ME; freezes the pipe while dmem is busy.
//  - Drives hold/bubble controls into PC, IF/ID, ID/EX, EX/ME and ME/WB; a bubble forces the stage register's valid_in to 0.

---
 rtl/pipe_ctrl_pkg.sv | 49 ++++
 rtl/pipe_ctrl_if.sv | 54 +++++
 rtl/pipe_ctrl_hazard_cmp.sv | 29 ++
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// opcode constants, FSM state encoding and the packed stage-control bundle.
package pipe_ctrl_pkg;

  // Major opcodes (RV32I encoding)
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Memory handshake sequencer states
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } fsm_e;

  // Everything the sequencer drives into the stage registers and dmem
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_bubble;
    logic id_ex_hold;
    logic id_ex_bubble;
    logic ex_me_hold;
    logic me_wb_bubble;
    logic pc_sel_redirect;
    logic dmem_req;
  } ctrl_t;

  // Controls while reset is asserted: nothing held, every bubble forced
  localparam ctrl_t CTRL_RESET = '{
    pc_hold:         1'b0,
    if_id_hold:      1'b0,
    if_id_bubble:    1'b1,
    id_ex_hold:      1'b0,
    id_ex_bubble:    1'b1,
    ex_me_hold:      1'b0,
    me_wb_bubble:    1'b1,
    pc_sel_redirect: 1'b0,
    dmem_req:        1'b0
  };

  // True when the ME stage holds a live load or store
  function automatic logic is_mem_op(input logic valid, input logic [6:0] opcode);
    return valid & ((opcode == OP_LOAD) | (opcode == OP_STORE));
  endfunction

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_if.sv
// Pipeline-status / stage-control bundle between the datapath and pipe_ctrl.
// master: the sequencer (reads stage status, drives stage controls and dmem_req).
// slave:  the datapath and data memory side.
interface pipe_ctrl_if;

  // ID stage status
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;

  // EX stage status
  logic       ex_valid;
  logic [6:0] ex_opcode;
  logic [4:0] ex_rd;
  logic       ex_redirect;

  // ME stage status and data-memory handshake
  logic       me_valid;
  logic [6:0] me_opcode;
  logic       dmem_ready;
  logic       dmem_req;

  // Stage register controls
  logic       pc_hold;
  logic       if_id_hold;
  logic       if_id_bubble;
  logic       id_ex_hold;
  logic       id_ex_bubble;
  logic       ex_me_hold;
  logic       me_wb_bubble;
  logic       pc_sel_redirect;
  logic       mem_err;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_opcode, ex_rd, ex_redirect,
    input  me_valid, me_opcode, dmem_ready,
    output dmem_req,
    output pc_hold, if_id_hold, if_id_bubble, id_ex_hold, id_ex_bubble,
    output ex_me_hold, me_wb_bubble, pc_sel_redirect, mem_err
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_opcode, ex_rd, ex_redirect,
    output me_valid, me_opcode, dmem_ready,
    input  dmem_req,
    input  pc_hold, if_id_hold, if_id_bubble, id_ex_hold, id_ex_bubble,
    input  ex_me_hold, me_wb_bubble, pc_sel_redirect, mem_err
  );

endinterface : pipe_ctrl_if

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Register x0 is hard-wired to zero and never conflicts.
module pipe_ctrl_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic [6:0] ex_opcode,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // Compare each consumed ID source against the EX load destination
  always_comb begin
    ex_is_load = ex_valid & (ex_opcode == OP_LOAD) & (ex_rd != 5'd0);
    rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
    rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
    load_use   = ex_is_load & id_valid & (rs1_hit | rs2_hit);
  end

endmodule : pipe_ctrl_hazard_cmp

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/ME/WB pipeline.
//  - one-cycle bubble on an EX-load / ID-use hazard
//  - PC redirect plus two-slot squash on a taken branch/jump resolved in EX
//  - data-memory handshake for the ME instruction, freezing the pipe while
//    dmem is busy and abandoning the access after MEM_TIMEOUT wait cycles
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall / flush
// counters; without it the perf ports read constant zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,  // wait cycles tolerated before abort, >= 1
  parameter int TO_W        = 5    // wait counter width, must hold MEM_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  pipe_ctrl_if.master bus,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE     = TO_W'(1);

  fsm_e            state_q,    state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q,  mem_err_d;

  logic  mem_op;
  logic  redirect;
  logic  load_use;
  logic  mem_freeze;   // whole pipe frozen behind dmem this cycle
  logic  mem_abort;    // wait budget exhausted, ME access dropped
  ctrl_t ctrl;

  assign mem_op   = is_mem_op(bus.me_valid, bus.me_opcode);
  assign redirect = bus.ex_valid & bus.ex_redirect;

  pipe_ctrl_hazard_cmp u_hazard_cmp (
    .id_valid   (bus.id_valid),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_valid   (bus.ex_valid),
    .ex_opcode  (bus.ex_opcode),
    .ex_rd      (bus.ex_rd),
    .load_use   (load_use)
  );

  // Classify the memory handshake outcome for this cycle
  always_comb begin
    mem_freeze = 1'b0;
    mem_abort  = 1'b0;
    unique case (state_q)
      RUN: begin
        // A miss on the first cycle already freezes the pipe
        mem_freeze = mem_op & ~bus.dmem_ready;
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          if (wait_cnt_q == TIMEOUT_CNT) mem_abort  = 1'b1;
          else                           mem_freeze = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State register: FSM, wait counter and sticky error flag
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic for the memory handshake
  always_comb begin
    // NOTE: hold-current defaults first, so no path leaves a signal unassigned (no latch).
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_op && !bus.dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic: stage holds/bubbles, redirect select and dmem request
  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else begin
      // The request stays up for the whole wait, including the release cycle
      ctrl.dmem_req = (state_q == MEM_WAIT) | mem_op;
      if (mem_freeze) begin
        // Full freeze: everything up to EX/ME holds, WB receives nothing.
        // Redirect and load-use wait, since EX and ID are frozen with them.
        ctrl.pc_hold      = 1'b1;
        ctrl.if_id_hold   = 1'b1;
        ctrl.id_ex_hold   = 1'b1;
        ctrl.ex_me_hold   = 1'b1;
        ctrl.me_wb_bubble = 1'b1;
      end else begin
        // Normal flow, zero-wait completion, or the release cycle of a wait.
        // A timed-out access must not reach WB.
        ctrl.me_wb_bubble = mem_abort;
        if (redirect) begin
          ctrl.pc_sel_redirect = 1'b1;
          ctrl.if_id_bubble    = 1'b1;
          ctrl.id_ex_bubble    = 1'b1;
        end else if (load_use) begin
          // ID/EX takes a bubble while PC and IF/ID replay the consumer
          ctrl.pc_hold      = 1'b1;
          ctrl.if_id_hold   = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end
      end
    end
  end

  assign bus.pc_hold         = ctrl.pc_hold;
  assign bus.if_id_hold      = ctrl.if_id_hold;
  assign bus.if_id_bubble    = ctrl.if_id_bubble;
  assign bus.id_ex_hold      = ctrl.id_ex_hold;
  assign bus.id_ex_bubble    = ctrl.id_ex_bubble;
  assign bus.ex_me_hold      = ctrl.ex_me_hold;
  assign bus.me_wb_bubble    = ctrl.me_wb_bubble;
  assign bus.pc_sel_redirect = ctrl.pc_sel_redirect;
  assign bus.dmem_req        = ctrl.dmem_req;
  assign bus.mem_err         = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters: PC-hold cycles and redirect cycles
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (ctrl.pc_hold && (perf_stall_q != '1))         perf_stall_d = perf_stall_q + 32'd1;
    if (ctrl.pc_sel_redirect && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_cnt    = '0;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (MEM_TIMEOUT=4). Directed scenarios are
// followed by randomized traffic; a reference model predicts every cycle's
// controls, the driver queues the prediction and a negedge monitor compares.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int N_RANDOM   = 3000;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_valid;
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       me_valid;
    logic [6:0] me_opcode;
    logic       dmem_ready;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        pc_hold, if_id_hold, if_id_bubble, id_ex_hold, id_ex_bubble;
    logic        ex_me_hold, me_wb_bubble, pc_sel_redirect, dmem_req, mem_err;
    logic [31:0] perf_stall, perf_flush;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .TO_W        (5)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .perf_stall_cycles (perf_stall),
    .perf_flush_cnt    (perf_flush)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  // Reference model state: how many cycles the current memory access has
  // already kept the pipe frozen (0 = no access outstanding), the sticky
  // error, and event totals since the last reset.
  int     m_frozen  = 0;
  bit     m_err     = 1'b0;
  longint m_stalls  = 0;
  longint m_flushes = 0;

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0b want %0b", name, c, act, want);
  endtask

  // Predict this cycle's outputs from the rules, then advance the model
  task automatic model_step(input stim_t s, output exp_t e);
    bit mem_op, busy, redirect, load_use, stuck, frozen, timed_out;
    e = '{default: '0};
    e.mem_err = m_err;
`ifdef PIPE_CTRL_PERF_EN
    e.perf_stall = 32'(m_stalls);
    e.perf_flush = 32'(m_flushes);
`endif
    if (s.rst) begin
      e.if_id_bubble = 1'b1;
      e.id_ex_bubble = 1'b1;
      e.me_wb_bubble = 1'b1;
      m_frozen = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
      return;
    end
    mem_op    = s.me_valid && (s.me_opcode == OP_LOAD || s.me_opcode == OP_STORE);
    busy      = (m_frozen > 0) || mem_op;
    redirect  = s.ex_valid && s.ex_redirect;
    load_use  = s.ex_valid && s.ex_opcode == OP_LOAD && s.ex_rd != 0 && s.id_valid &&
                ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
    stuck     = busy && !s.dmem_ready;
    frozen    = stuck && (m_frozen < TB_TIMEOUT);
    timed_out = stuck && (m_frozen >= TB_TIMEOUT);
    e.dmem_req = busy;
    if (frozen) begin
      e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_hold = 1; e.ex_me_hold = 1; e.me_wb_bubble = 1;
      m_frozen++;
    end else begin
      e.me_wb_bubble = timed_out;
      if (timed_out) m_err = 1'b1;
      m_frozen = 0;
      if (redirect) begin
        e.pc_sel_redirect = 1; e.if_id_bubble = 1; e.id_ex_bubble = 1;
      end else if (load_use) begin
        e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_bubble = 1;
      end
    end
    if (e.pc_hold && m_stalls < 64'hFFFF_FFFF)          m_stalls++;
    if (e.pc_sel_redirect && m_flushes < 64'hFFFF_FFFF) m_flushes++;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clock);
    #1;
    reset           = s.rst;
    bus.id_valid    = s.id_valid;
    bus.id_rs1      = s.id_rs1;
    bus.id_rs2      = s.id_rs2;
    bus.id_use_rs1  = s.id_use_rs1;
    bus.id_use_rs2  = s.id_use_rs2;
    bus.ex_valid    = s.ex_valid;
    bus.ex_opcode   = s.ex_opcode;
    bus.ex_rd       = s.ex_rd;
    bus.ex_redirect = s.ex_redirect;
    bus.me_valid    = s.me_valid;
    bus.me_opcode   = s.me_opcode;
    bus.dmem_ready  = s.dmem_ready;
    model_step(s, e);
    e.cyc = cyc;
    cyc++;
    exp_q.push_back(e);
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return OP_LOAD;
      1:       return OP_STORE;
      2:       return OP_BRANCH;
      3:       return OP_JAL;
      default: return 7'b0110011;
    endcase
  endfunction

  // While an access is outstanding the datapath is frozen, so only the
  // memory response (and the occasional reset) changes.
  function automatic stim_t rand_stim(input stim_t prev, input bit waiting);
    stim_t s;
    s = waiting ? prev : '0;
    if (!waiting) begin
      s.id_valid    = $urandom_range(0, 3) != 0;
      s.id_rs1      = 5'($urandom_range(0, 3));
      s.id_rs2      = 5'($urandom_range(0, 3));
      s.id_use_rs1  = $urandom_range(0, 1) != 0;
      s.id_use_rs2  = $urandom_range(0, 1) != 0;
      s.ex_valid    = $urandom_range(0, 3) != 0;
      s.ex_opcode   = rand_op();
      s.ex_rd       = 5'($urandom_range(0, 3));
      s.ex_redirect = $urandom_range(0, 4) == 0;
      s.me_valid    = $urandom_range(0, 2) != 0;
      s.me_opcode   = rand_op();
    end
    s.dmem_ready = $urandom_range(0, 9) < 5;
    s.rst        = $urandom_range(0, 199) == 0;
    return s;
  endfunction

  // Monitor: compare the DUT against the queued prediction mid-cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ctrl{pch,ifh,ifb,idh,idb,exh,mwb,red,req}", e.cyc,
              64'({bus.pc_hold, bus.if_id_hold, bus.if_id_bubble, bus.id_ex_hold, bus.id_ex_bubble,
                   bus.ex_me_hold, bus.me_wb_bubble, bus.pc_sel_redirect, bus.dmem_req}),
              64'({e.pc_hold, e.if_id_hold, e.if_id_bubble, e.id_ex_hold, e.id_ex_bubble,
                   e.ex_me_hold, e.me_wb_bubble, e.pc_sel_redirect, e.dmem_req}));
        check("mem_err", e.cyc, 64'(bus.mem_err), 64'(e.mem_err));
        check("perf_stall_cycles", e.cyc, 64'(perf_stall), 64'(e.perf_stall));
        check("perf_flush_cnt", e.cyc, 64'(perf_flush), 64'(e.perf_flush));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t idle, s, lu, prev;
    idle = '0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_valid = 0; bus.ex_opcode = 0; bus.ex_rd = 0; bus.ex_redirect = 0;
    bus.me_valid = 0; bus.me_opcode = 0; bus.dmem_ready = 0;

    // Reset state
    s = idle; s.rst = 1'b1;
    drive(s); drive(s);
    drive(idle);

    // Load-use on rs1 (rd=5): one stall, then clear once EX holds the bubble
    lu = idle;
    lu.ex_valid = 1; lu.ex_opcode = OP_LOAD; lu.ex_rd = 5'd5;
    lu.id_valid = 1; lu.id_use_rs1 = 1; lu.id_rs1 = 5'd5;
    drive(lu);
    s = lu; s.ex_valid = 0;
    drive(s);
    // Same pattern on x0: no hazard
    s = lu; s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
    drive(s);
    // Load-use through rs2
    s = idle;
    s.ex_valid = 1; s.ex_opcode = OP_LOAD; s.ex_rd = 5'd7;
    s.id_valid = 1; s.id_use_rs2 = 1; s.id_rs2 = 5'd7;
    drive(s);
    // Redirect beats a simultaneous load-use match
    s = lu; s.ex_redirect = 1;
    drive(s);
    drive(idle);   // perf: 2 stalls, 1 flush

    // STORE waits 3 cycles, completes on the 4th
    s = idle; s.me_valid = 1; s.me_opcode = OP_STORE;
    repeat (3) drive(s);
    s.dmem_ready = 1;
    drive(s);
    drive(idle);

    // Redirect held in EX during a wait is taken in the release cycle
    s = idle; s.me_valid = 1; s.me_opcode = OP_LOAD; s.ex_valid = 1; s.ex_redirect = 1;
    repeat (2) drive(s);
    s.dmem_ready = 1;
    drive(s);

    // Timeout: LOAD never answered -> abort after 4 wait cycles, error sticks
    s = idle; s.me_valid = 1; s.me_opcode = OP_LOAD;
    repeat (TB_TIMEOUT + 1) drive(s);
    drive(idle); drive(idle);

    // Reset in the middle of a wait clears the FSM and the error flag
    s = idle; s.me_valid = 1; s.me_opcode = OP_STORE;
    repeat (2) drive(s);
    s.rst = 1;
    drive(s);
    s = idle; s.rst = 1;
    drive(s);
    drive(idle);
    s = idle; s.me_valid = 1; s.me_opcode = OP_STORE; s.dmem_ready = 1;
    drive(s);

    // Randomized traffic
    prev = idle;
    for (int i = 0; i < N_RANDOM; i++) begin
      s = rand_stim(prev, m_frozen > 0);
      drive(s);
      prev = s;
    end
    drive(idle);

    // Let the monitor drain the last predictions
    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipe_ctrl
